count_display_mux: RTL

Display stage for the push-button counter design. It takes the three 8-bit event counts (press, hold, release) from the counter stage and converts each to decimal with a sequential double-dabble engine. It then time-multiplexes the resulting digits onto the 8-digit, active-low 7-segment display. It consumes the counter outputs directly and drives the board `segments`/`anodos` pins.

---
 rtl/count_display_mux.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/count_display_mux.sv
// Display stage: one shared sequential double-dabble engine converts the three
// event counts to BCD, and a free-running scanner multiplexes the 8 digits.
module count_display_mux #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] press_count,
    input  logic [7:0] hold_count,
    input  logic [7:0] release_count,
    output logic [6:0] segments,
    output logic [7:0] anodos
);
    localparam int            DW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_DASH   = 7'b1111110;
    localparam logic [6:0]    SEG_ZERO   = 7'b0000001;

    typedef enum logic [1:0] {LOAD, SHIFT, STORE} state_t;
    typedef enum logic [1:0] {CH_PRESS, CH_HOLD, CH_RELEASE} chan_t;

    state_t      state;
    state_t      state_next;
    chan_t       chan;
    logic        load_en;
    logic        shift_en;
    logic        store_en;
    logic [2:0]  bit_cnt;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [7:0]  sel_input;

    // Slot order matches the scan index; slot 8 keeps hold hundreds for overflow.
    logic [3:0]  digit      [9];
    logic [3:0]  digit_next [9];

    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_next;
    logic [2:0]    index;
    logic [2:0]    index_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    state_next = SHIFT;
            SHIFT:   state_next = (bit_cnt == 3'd7) ? STORE : SHIFT;
            STORE:   state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        load_en  = (state == LOAD);
        shift_en = (state == SHIFT);
        store_en = (state == STORE);
    end

    always_comb begin
        case (chan)
            CH_PRESS:   sel_input = press_count;
            CH_HOLD:    sel_input = hold_count;
            CH_RELEASE: sel_input = release_count;
            default:    sel_input = press_count;
        endcase
    end

    // Add-3 correction is applied to each nibble before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bin     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            chan    <= CH_PRESS;
        end else if (load_en) begin
            bin     <= sel_input;
            bcd     <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            {bcd, bin} <= {bcd_adj[10:0], bin, 1'b0};
            bit_cnt    <= bit_cnt + 3'd1;
        end else if (store_en) begin
            case (chan)
                CH_PRESS: chan <= CH_HOLD;
                CH_HOLD:  chan <= CH_RELEASE;
                default:  chan <= CH_PRESS;
            endcase
        end
    end

    always_comb begin
        digit_next = digit;
        if (store_en) begin
            case (chan)
                CH_PRESS: begin
                    digit_next[7] = bcd[11:8];
                    digit_next[6] = bcd[7:4];
                    digit_next[5] = bcd[3:0];
                end
                CH_HOLD: begin
                    digit_next[8] = bcd[11:8];
                    digit_next[4] = bcd[7:4];
                    digit_next[3] = bcd[3:0];
                end
                default: begin
                    digit_next[2] = bcd[11:8];
                    digit_next[1] = bcd[7:4];
                    digit_next[0] = bcd[3:0];
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                digit[i] <= '0;
            end
        end else begin
            digit <= digit_next;
        end
    end

    always_comb begin
        dwell_next = dwell + 1'b1;
        index_next = index;
        if (dwell == DWELL_LAST) begin
            dwell_next = '0;
            index_next = index + 3'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dwell <= '0;
            index <= '0;
        end else begin
            dwell <= dwell_next;
            index <= index_next;
        end
    end

    // Outputs decode next-state values so they stay aligned with index and digits.
    always_comb begin
        seg_next = decode(digit_next[index_next]);
        if ((index_next == 3'd3 || index_next == 3'd4) && digit_next[8] != 4'd0) begin
            seg_next = SEG_DASH;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            segments <= SEG_ZERO;
            anodos   <= 8'b11111110;
        end else begin
            segments <= seg_next;
            anodos   <= ~(8'b1 << index_next);
        end
    end
endmodule
